// File: rtl/draw_pkg.sv
// draw_pkg: opcodes, dispatcher states and engine count shared by the dispatcher and coordinate muxes
package draw_pkg;
  localparam int NENG = 5;
  localparam logic [3:0] OP_CF = 4'd0, OP_CD = 4'd1, OP_RF = 4'd2, OP_RD = 4'd3, OP_LD = 4'd4;
  localparam logic [3:0] OP_FU = 4'd10, OP_IDLE = 4'd15;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;
  function automatic logic op_valid(input logic [3:0] op);
    return op <= OP_LD || op == OP_FU;
  endfunction
  function automatic logic [NENG-1:0] eng_mask(input logic [3:0] op);
    return op <= OP_LD ? NENG'(1) << op : '0;
  endfunction
endpackage

// File: rtl/draw_dispatch_if.sv
// draw_dispatch_if: command handshake, engine start/done and SEL bus of the draw dispatcher
interface draw_dispatch_if #(parameter int CW = 9);
  import draw_pkg::*;
  logic cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [CW-1:0] x0, y0, x1, y1;
  logic [NENG-1:0] start, done;
  logic fu_start, fu_done, busy, err;
  logic [3:0] sel;
  modport slave(
    input cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, done, fu_done,
    output cmd_ready, x0, y0, x1, y1, start, fu_start, sel, busy, err
  );
  modport master(
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, done, fu_done,
    input cmd_ready, x0, y0, x1, y1, start, fu_start, sel, busy, err
  );
endinterface

// File: rtl/dispatch_watchdog.sv
// dispatch_watchdog: counts WAIT cycles and flags the cycle in which the count would reach TIMEOUT
module dispatch_watchdog #(parameter int TIMEOUT = 4096) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire_o = TIMEOUT != 0 && en_i && cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/draw_dispatch.sv
// draw_dispatch: accepts one draw command at a time, starts its engine and holds SEL
// until the engine's final coordinate has been flushed through the registered muxes.
module draw_dispatch import draw_pkg::*; #(
  parameter int TIMEOUT = 4096,
  parameter int CW = 9
) (
  input logic clk,
  input logic rst,
  draw_dispatch_if.slave bus
);
  state_t state_q, state_d;
  logic [3:0] op_q, op_d, sel_q, sel_d;
  logic [3:0][CW-1:0] opd_q, opd_d;
  logic err_q, err_d, expire, sel_done;
  // only the engine that was started may complete the command
  assign sel_done = op_q == OP_FU ? bus.fu_done : |(bus.done & eng_mask(op_q));
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    sel_d = sel_q;
    opd_d = opd_q;
    err_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        op_d = bus.cmd_op;
        opd_d = {bus.cmd_y1, bus.cmd_x1, bus.cmd_y0, bus.cmd_x0};
        if (op_valid(bus.cmd_op)) begin
          state_d = S_START;
          sel_d = bus.cmd_op;
        end else err_d = bus.cmd_op != OP_IDLE;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: if (sel_done || expire) begin
        state_d = S_HOLD;
        err_d = !sel_done;
      end
      S_HOLD: begin
        state_d = S_IDLE;
        sel_d = OP_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= OP_IDLE;
      sel_q <= OP_IDLE;
      opd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      sel_q <= sel_d;
      opd_q <= opd_d;
      err_q <= err_d;
    end
  dispatch_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == S_START),
    .en_i(state_q == S_WAIT),
    .expire_o(expire)
  );
  assign bus.cmd_ready = state_q == S_IDLE;
  assign bus.busy = state_q != S_IDLE;
  assign bus.sel = sel_q;
  assign bus.err = err_q;
  assign bus.start = state_q == S_START ? eng_mask(op_q) : '0;
  assign bus.fu_start = state_q == S_START && op_q == OP_FU;
  assign bus.x0 = opd_q[0];
  assign bus.y0 = opd_q[1];
  assign bus.x1 = opd_q[2];
  assign bus.y1 = opd_q[3];
endmodule

// File: tb/tb_draw_dispatch.sv
// tb_draw_dispatch: randomized command stream checked cycle by cycle against a command-level timing model
module tb_draw_dispatch;
  import draw_pkg::*;
  localparam int CW = 9;
  localparam int TO = 8;
  localparam int SW = 13 + 4 * CW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [CW-1:0] ex0 = '0, ey0 = '0, ex1 = '0, ey1 = '0;
  logic [SW-1:0] obs;
  draw_dispatch_if #(.CW(CW)) bus();
  draw_dispatch #(.TIMEOUT(TO), .CW(CW)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign obs = {bus.cmd_ready, bus.busy, bus.sel, bus.start, bus.fu_start, bus.err,
                bus.x0, bus.y0, bus.x1, bus.y1};
  function automatic logic [SW-1:0] snap(input logic r, input logic b, input logic [3:0] s,
                                         input logic [4:0] st, input logic f, input logic e);
    return {r, b, s, st, f, e, ex0, ey0, ex1, ey1};
  endfunction
  // one command: c=0 is the handshake cycle, expected outputs follow from op and done timing
  task automatic run_cmd(input string name, input logic [3:0] op, input logic [CW-1:0] a,
                         input logic [CW-1:0] b, input logic [CW-1:0] r, input logic [CW-1:0] d,
                         input int done_at, input bit hold);
    bit ok, fu, hit, pick;
    logic [4:0] m;
    int n, last;
    logic [SW-1:0] exp_v;
    ok = op <= 4 || op == 10;
    fu = op == 10;
    m = op <= 4 ? 5'b1 << op : 5'd0;
    hit = done_at >= 1 && done_at <= TO;
    n = hit ? done_at : TO;
    last = ok ? n + 3 : 1;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        if (!ok) exp_v = snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, op != 4'd15);
        else if (c == 1) exp_v = snap(1'b0, 1'b1, op, m, fu, 1'b0);
        else if (c <= n + 1) exp_v = snap(1'b0, 1'b1, op, 5'd0, 1'b0, 1'b0);
        else if (c == n + 2) exp_v = snap(1'b0, 1'b1, op, 5'd0, 1'b0, !hit);
        else exp_v = snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL %s op=%0d c=%0d got=%h want=%h (rdy,busy,sel,start,fu_start,err,x0,y0,x1,y1)",
                   name, op, c, obs, exp_v);
        end
      end
      bus.cmd_valid = c == 0 || hold;
      bus.cmd_op = c == 0 ? op : OP_LD;
      bus.cmd_x0 = c == 0 ? a : CW'($urandom);
      bus.cmd_y0 = c == 0 ? b : CW'($urandom);
      bus.cmd_x1 = c == 0 ? r : CW'($urandom);
      bus.cmd_y1 = c == 0 ? d : CW'($urandom);
      bus.done = 5'($urandom);
      bus.fu_done = 1'($urandom);
      if (ok && c >= 2 && c <= n + 1) begin
        pick = c - 1 == done_at;
        if (fu) bus.fu_done = pick;
        else bus.done = (bus.done & ~m) | (pick ? m : 5'd0);
      end
      if (c == 0) begin
        ex0 = a;
        ey0 = b;
        ex1 = r;
        ey1 = d;
      end
      if (c < last) @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    ex0 = '0; ey0 = '0; ex1 = '0; ey1 = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs !== snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_held got=%h want=%h", obs, snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, 1'b0));
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_released got=%h want=%h", obs, snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, 1'b0));
    end
  endtask
  task automatic test_rect_fill;
    run_cmd("rf_basic", OP_RF, 9'd10, 9'd20, 9'd100, 9'd50, 4, 1'b0);
  endtask
  task automatic test_frame_update;
    run_cmd("fu_long", OP_FU, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 6, 1'b0);
    run_cmd("fu_fast", OP_FU, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 1, 1'b0);
  endtask
  task automatic test_bad_op;
    run_cmd("bad_op7", 4'd7, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 0, 1'b0);
    run_cmd("noop15", OP_IDLE, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 0, 1'b0);
    run_cmd("bad_op13", 4'd13, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 0, 1'b1);
  endtask
  task automatic test_timeout;
    run_cmd("ld_timeout", OP_LD, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 0, 1'b0);
    run_cmd("ld_done_at_limit", OP_LD, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), TO, 1'b0);
    run_cmd("ld_done_late", OP_LD, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), TO + 1, 1'b0);
  endtask
  task automatic test_reset_mid;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_CD;
    bus.cmd_x0 = CW'($urandom);
    bus.cmd_y0 = CW'($urandom);
    bus.cmd_x1 = CW'($urandom);
    bus.cmd_y1 = CW'($urandom);
    bus.done = 5'd0;
    bus.fu_done = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ex0 = '0; ey0 = '0; ex1 = '0; ey1 = '0;
    #1;
    vectors++;
    if (obs !== snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_mid got=%h want=%h", obs, snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, 1'b0));
    end
    @(negedge clk);
    rst = 1'b0;
    bus.done = 5'b00010;
    bus.fu_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, 1'b0)) begin
        miscompares++;
        $display("FAIL late_done i=%0d got=%h want=%h", i, obs, snap(1'b1, 1'b0, 4'd15, 5'd0, 1'b0, 1'b0));
      end
    end
    bus.done = 5'd0;
    bus.fu_done = 1'b0;
    run_cmd("after_reset", OP_CF, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 2, 1'b0);
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      run_cmd("b2b_ld", OP_LD, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 1, 1'b1);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic test_random;
    logic [3:0] op;
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) op = 4'(r);
      else if (r < 7) op = OP_FU;
      else if (r == 7) op = OP_IDLE;
      else begin
        op = 4'($urandom_range(5, 14));
        if (op == OP_FU) op = 4'd11;
      end
      run_cmd("random", op, CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom),
              $urandom_range(0, 10), 1'($urandom));
    end
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 4'd0;
    bus.cmd_x0 = '0;
    bus.cmd_y0 = '0;
    bus.cmd_x1 = '0;
    bus.cmd_y1 = '0;
    bus.done = 5'd0;
    bus.fu_done = 1'b0;
    test_reset();
    test_rect_fill();
    test_frame_update();
    test_bad_op();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/draw_dispatch.md
# draw_dispatch

Command front-end for the drawing pipeline: accepts one draw command at a time over a valid/ready handshake and decodes its opcode. It starts the matching engine (circle fill/draw, rectangle fill/draw, line draw, frame update) and waits for that engine's done. It drives the 4-bit SEL bus that steers the registered X/Y coordinate muxes, and returns SEL to IDLE only once the engine's last coordinate has passed through those muxes.

## Interface
- TIMEOUT, default 4096: max cycles in WAIT before abort; 0 disables the watchdog.
- CW, default 9: coordinate width.
- CLK  in  1  clock; one clock, all logic on posedge CLK.
- RST  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE state.
- cmd_op  in  4  opcode: CF=0, CD=1, RF=2, RD=3, LD=4, FU=10, IDLE=15.
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  CW each  operands (x1 is the radius for CF/CD).
- x0, y0, x1, y1  out  CW each  latched operands broadcast to all engines.
- start  out  5  one-hot start pulse, bit i = opcode i (CF..LD).
- fu_start  out  1  frame-update start pulse.
- done  in  5  per-engine done, bit i = opcode i.
- fu_done  in  1  frame-update done.
- SEL  out  4  mux select, registered.
- busy  out  1  high in any state except IDLE.
- err  out  1  one-cycle pulse on bad opcode or timeout.

## Operation
- States: S_IDLE, S_START, S_WAIT, S_HOLD.
- S_IDLE: cmd_ready=1, SEL=15.
  - On cmd_valid&&cmd_ready, latch the operands and the opcode.
  - Opcodes 0–4 and 10 go to S_START.
  - Opcode 15 is a no-op: accepted, stays in S_IDLE, no err.
  - Any other opcode is accepted and dropped: err pulses next cycle, stays in S_IDLE.
- S_START, one cycle:
  - SEL=opcode.
  - start[op] high, or fu_start high for FU.
  - Go to S_WAIT.
- S_WAIT:
  - SEL held.
  - Only the selected done bit (or fu_done) is sampled; done from other engines is ignored.
  - On selected done, go to S_HOLD.
- S_HOLD, one cycle: SEL still held so the mux registers flush the engine's final coordinate; then go to S_IDLE.
- Watchdog:
  - Counter of width $clog2(TIMEOUT+1), cleared on entering S_WAIT, increments each S_WAIT cycle.
  - When it reaches TIMEOUT with no done: err pulses, go to S_HOLD (same flush path).
  - Done and timeout in the same cycle: done wins, no err.
- Operand outputs change only on an accepted command; they are stable from S_START through S_HOLD.
- Reset, including mid-command: state=S_IDLE, SEL=15, start=0, fu_start=0, busy=0, err=0, x0/y0/x1/y1=0, counter=0, cmd_ready=1 once RST deasserts. An engine already started is not told to stop; its later done is ignored because it does not arrive in S_WAIT.

## Timing
- Cycle 0: handshake.
- Cycle 1: S_START, with SEL and start valid at the cycle-1 outputs.
- Cycles 2..N: S_WAIT.
- Selected done sampled high in cycle N: N+1 is S_HOLD, N+2 is S_IDLE with SEL=15 and cmd_ready=1.
- Minimum command period is 4 cycles (done high in the first S_WAIT cycle).
- start and fu_start are exactly one cycle wide.
- err is registered, one cycle, in the cycle after the triggering event.
- A done already high in S_START is not sampled; done is sampled only in S_WAIT.

## Structure
- Shared package draw_pkg holds:
  - opcode constants OP_CF=0, OP_CD=1, OP_RF=2, OP_RD=3, OP_LD=4, OP_FU=10, OP_IDLE=15;
  - the state enum;
  - the engine count NENG=5.
- The same package constants are used by the coordinate muxes.
- One sub-module: dispatch_watchdog, a clear/enable counter with a TIMEOUT parameter and a one-cycle expire output.

## Test plan
- After reset: SEL=15, cmd_ready=1, busy=0, all starts 0. Send op=2 (RF), x0=10, y0=20, x1=100, y1=50 → cycle 1: SEL=2, start=5'b00100, x0..y1 as sent. Assert done[2] on cycle 5 → S_HOLD cycle 6, SEL=15 and cmd_ready=1 on cycle 7.
- op=10 (FU): fu_start pulses once, start stays 0, SEL=10. Assert done[0] while in S_WAIT → no effect; fu_done then completes the command normally.
- op=7, then op=15 → op=7 gives one err pulse and no start; op=15 gives no err; cmd_ready stays 1 throughout.
- TIMEOUT=8, op=4 with no done → exactly 8 WAIT cycles, then err pulses, S_HOLD, back to IDLE with SEL=15. Repeat with done[4] arriving on the 8th WAIT cycle → no err.
- Assert RST during S_WAIT of op=1 → all outputs at reset values immediately. A later done[1] is ignored. The next command op=0 dispatches normally.
- Back-to-back: cmd_valid held high with four LD commands and done returned immediately each time → one command every 4 cycles, with operands updating only at each handshake.
